// File: rtl/write_buffer_drain_if.sv
// Bus bundle between the bypass write FIFO, the drain block and memory.
// master: drain side (pops FIFO, drives av_*); slave: FIFO/memory/ctrl side.
interface write_buffer_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int FW   = ADDR_WIDTH + BE_W + DATA_WIDTH;

  logic                  fifo_empty;
  logic                  fifo_read;
  logic [FW-1:0]         fifo_data;
  logic [ADDR_WIDTH-1:0] av_address;
  logic [BE_W-1:0]       av_byteenable;
  logic [DATA_WIDTH-1:0] av_writedata;
  logic                  av_write;
  logic                  av_waitrequest;
  logic                  flush_req;
  logic                  flush_done;
  logic                  idle;
  logic                  err;
  logic [15:0]           wr_count;

  modport master (
    input  fifo_empty, fifo_data,
    input  av_waitrequest, flush_req,
    output fifo_read,
    output av_address, av_byteenable,
    output av_writedata, av_write,
    output flush_done, idle, err,
    output wr_count
  );

  modport slave (
    output fifo_empty, fifo_data,
    output av_waitrequest, flush_req,
    input  fifo_read,
    input  av_address, av_byteenable,
    input  av_writedata, av_write,
    input  flush_done, idle, err,
    input  wr_count
  );
endinterface

// File: rtl/write_buffer_drain.sv
// Drains the bypass write FIFO into single-beat Avalon writes.
// Ports: clk, rest (sync, active-high), bus (master modport of the bundle).
module write_buffer_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rest,
  write_buffer_drain_if.master bus
);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE =
    WAIT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  accept;
  logic                  load;
  logic                  done;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    accept  = (state_q == S_WRITE) &&
              !bus.av_waitrequest;
    load    = !bus.fifo_empty &&
              ((state_q == S_IDLE) || accept);
    done    = pend_q && !rest &&
              (state_q == S_IDLE) &&
              bus.fifo_empty;

    // A load after acceptance chains the next
    // entry without an idle bubble.
    if (load) begin
      state_d = S_WRITE;
      {addr_d, be_d, data_d} = bus.fifo_data;
    end else if (accept) begin
      state_d = S_IDLE;
    end

    if (accept) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (load) begin
      wait_d = '0;
    end else if ((state_q == S_WRITE) &&
                 bus.av_waitrequest &&
                 (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_ONE;
    end

    // Look at the next count so err rises in
    // the cycle after the last tolerated stall.
    err_d  = err_q || (wait_d == WAIT_MAX);
    // A new request in the done cycle re-arms.
    pend_d = (pend_q && !done) || bus.flush_req;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
      wait_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      be_q   <= be_d;
      data_q <= data_d;
      wait_q <= wait_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign bus.fifo_read     = load && !rest;
  assign bus.av_write      = (state_q == S_WRITE);
  assign bus.av_address    = addr_q;
  assign bus.av_byteenable = be_q;
  assign bus.av_writedata  = data_q;
  assign bus.idle          = (state_q == S_IDLE) &&
                             bus.fifo_empty;
  assign bus.flush_done    = done;
  assign bus.err           = err_q;
  assign bus.wr_count      = cnt_q;
endmodule
